// File: rtl/bus_mux_reg.sv
// -----------------------------------------------------------------------------
// bus_mux_reg
//
// Registered CPU bus multiplexer. One of N_SRC flattened data sources is
// placed on the shared bus according to a set of one-hot "Xout" strobes.
// The strobes are priority-encoded internally: the lowest-numbered asserted
// strobe wins. If more than one strobe is asserted, the cycle is flagged as
// contention. The flag drives a one-cycle pulse, a sticky bit and a
// saturating counter.
//
// Parameters:
//   DATA_W    width of each source and of the bus
//   N_SRC     number of sources (2..64)
//   IDLE_HOLD 0: bus_out goes to zero when no strobe is active
//             1: bus_out holds its last value when no strobe is active
//   CNT_W     width of the saturating contention counter
//
// Optional feature:
//   BUS_MUX_PARITY_EN  when defined, adds bus_parity. This is the registered
//                      XOR reduction of the value loaded into bus_out.
//
// Ports:
//   clk                rising-edge clock
//   clear              synchronous reset, active-low
//   src_data           flattened sources; source i = [i*DATA_W +: DATA_W]
//   src_out            one-hot source strobes
//   stall              1 freezes every register
//   err_clr            clears contention_sticky / contention_cnt
//   bus_out            registered bus value
//   bus_valid          1 = bus_out came from a strobed source
//   bus_sel            registered index of the selected source
//   contention         one-cycle pulse: more than one strobe was sampled
//   contention_sticky  set on any contention until err_clr or reset
//   contention_cnt     saturating count of contention cycles
//   bus_parity         (BUS_MUX_PARITY_EN only) parity of bus_out
// -----------------------------------------------------------------------------
module bus_mux_reg #(
    parameter int DATA_W    = 32,
    parameter int N_SRC     = 32,
    parameter int IDLE_HOLD = 0,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic [N_SRC*DATA_W-1:0]    src_data,
    input  logic [N_SRC-1:0]           src_out,
    input  logic                       stall,
    input  logic                       err_clr,
    output logic [DATA_W-1:0]          bus_out,
    output logic                       bus_valid,
    output logic [$clog2(N_SRC)-1:0]   bus_sel,
    output logic                       contention,
    output logic                       contention_sticky,
`ifdef BUS_MUX_PARITY_EN
    output logic                       bus_parity,
`endif
    output logic [CNT_W-1:0]           contention_cnt
);

    localparam int SEL_W = $clog2(N_SRC);

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

    // Even parity of a bus word (XOR reduction).
    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // ---- stage p0: combinational decode of the sampled strobes ----
    logic               hit_p0;
    logic [SEL_W-1:0]   sel_p0;
    logic [DATA_W-1:0]  data_p0;
    logic               multi_p0;

    always_comb begin
        hit_p0  = 1'b0;
        sel_p0  = '0;
        data_p0 = '0;
        // Scan from the top down so that the lowest asserted index is the
        // last one written. Only the winning source is ever copied, so an
        // unselected source (even one carrying X) never reaches the bus.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_out[i]) begin
                hit_p0  = 1'b1;
                sel_p0  = SEL_W'(i);
                data_p0 = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // popcount >= 2 without building a full adder tree: flag any strobe
    // that is seen after another strobe has already been seen.
    always_comb begin
        logic seen;
        seen     = 1'b0;
        multi_p0 = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_out[i]) begin
                if (seen) begin
                    multi_p0 = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

    // Next values for the output register.
    logic [DATA_W-1:0]  data_nxt;
    logic               sticky_nxt;
    logic [CNT_W-1:0]   cnt_nxt;

    always_comb begin
        if (hit_p0) begin
            data_nxt = data_p0;
        end else if (IDLE_HOLD != 0) begin
            data_nxt = bus_out;
        end else begin
            data_nxt = '0;
        end

        // A contention detected in the same cycle as err_clr takes
        // priority: the flag stays set and the count restarts at one.
        sticky_nxt = contention_sticky;
        cnt_nxt    = contention_cnt;
        if (err_clr) begin
            sticky_nxt = 1'b0;
            cnt_nxt    = '0;
        end
        if (multi_p0) begin
            sticky_nxt = 1'b1;
            cnt_nxt    = err_clr ? CNT_W'(1) : sat_inc(contention_cnt);
        end
    end

    // ---- stage p1: output register ----
    always_ff @(posedge clk) begin
        if (!clear) begin
            bus_out           <= '0;
            bus_valid         <= 1'b0;
            bus_sel           <= '0;
            contention        <= 1'b0;
            contention_sticky <= 1'b0;
            contention_cnt    <= '0;
        end else if (!stall) begin
            bus_out           <= data_nxt;
            bus_valid         <= hit_p0;
            bus_sel           <= sel_p0;
            contention        <= multi_p0;
            contention_sticky <= sticky_nxt;
            contention_cnt    <= cnt_nxt;
        end
    end

`ifdef BUS_MUX_PARITY_EN
    // Parity is computed from the value being loaded. In hold mode this
    // reproduces the parity of the held word.
    always_ff @(posedge clk) begin
        if (!clear) begin
            bus_parity <= 1'b0;
        end else if (!stall) begin
            bus_parity <= parity_of(data_nxt);
        end
    end
`else
    // Without the parity port, the helper function is never called.
    logic unused_parity;
    assign unused_parity = parity_of('0);
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// -----------------------------------------------------------------------------
// tb_bus_mux_reg
//
// Directed bench for bus_mux_reg. It uses two instances that share the same
// inputs. Instance 0 uses IDLE_HOLD=0 and instance 1 uses IDLE_HOLD=1, so
// both idle behaviours are checked on the same stimulus.
// -----------------------------------------------------------------------------
module tb_bus_mux_reg;

    localparam int DATA_W = 32;
    localparam int N_SRC  = 32;
    localparam int CNT_W  = 8;
    localparam int SEL_W  = $clog2(N_SRC);

    logic                     clk = 1'b0;
    logic                     clear;
    logic [N_SRC*DATA_W-1:0]  src_data;
    logic [N_SRC-1:0]         src_out;
    logic                     stall;
    logic                     err_clr;

    logic [DATA_W-1:0]  out0, out1;
    logic               vld0, vld1;
    logic [SEL_W-1:0]   sel0, sel1;
    logic               con0, con1;
    logic               stk0, stk1;
    logic [CNT_W-1:0]   cnt0, cnt1;
`ifdef BUS_MUX_PARITY_EN
    logic               par0, par1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_mux_reg #(.DATA_W(DATA_W), .N_SRC(N_SRC), .IDLE_HOLD(0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .clear(clear), .src_data(src_data), .src_out(src_out),
        .stall(stall), .err_clr(err_clr), .bus_out(out0), .bus_valid(vld0),
        .bus_sel(sel0), .contention(con0), .contention_sticky(stk0),
`ifdef BUS_MUX_PARITY_EN
        .bus_parity(par0),
`endif
        .contention_cnt(cnt0)
    );

    bus_mux_reg #(.DATA_W(DATA_W), .N_SRC(N_SRC), .IDLE_HOLD(1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .clear(clear), .src_data(src_data), .src_out(src_out),
        .stall(stall), .err_clr(err_clr), .bus_out(out1), .bus_valid(vld1),
        .bus_sel(sel1), .contention(con1), .contention_sticky(stk1),
`ifdef BUS_MUX_PARITY_EN
        .bus_parity(par1),
`endif
        .contention_cnt(cnt1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Compare both instances against expected values. The idle-hold
    // instance has its own expected bus word.
    task automatic chk_all(input string name, input logic [31:0] e_out0, input logic [31:0] e_out1,
                           input logic e_vld, input logic [SEL_W-1:0] e_sel, input logic e_con,
                           input logic e_stk, input logic [CNT_W-1:0] e_cnt);
        chk({name, ".out0"}, 64'(out0), 64'(e_out0));
        chk({name, ".out1"}, 64'(out1), 64'(e_out1));
        chk({name, ".valid0"}, 64'(vld0), 64'(e_vld));
        chk({name, ".valid1"}, 64'(vld1), 64'(e_vld));
        chk({name, ".sel0"}, 64'(sel0), 64'(e_sel));
        chk({name, ".sel1"}, 64'(sel1), 64'(e_sel));
        chk({name, ".cont0"}, 64'(con0), 64'(e_con));
        chk({name, ".cont1"}, 64'(con1), 64'(e_con));
        chk({name, ".sticky0"}, 64'(stk0), 64'(e_stk));
        chk({name, ".sticky1"}, 64'(stk1), 64'(e_stk));
        chk({name, ".cnt0"}, 64'(cnt0), 64'(e_cnt));
        chk({name, ".cnt1"}, 64'(cnt1), 64'(e_cnt));
`ifdef BUS_MUX_PARITY_EN
        chk({name, ".par0"}, 64'(par0), 64'(^e_out0));
        chk({name, ".par1"}, 64'(par1), 64'(^e_out1));
`endif
    endtask

    // Advance one edge, then settle away from it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string              name;
        logic               clear;
        logic               stall;
        logic               err_clr;
        logic [N_SRC-1:0]   src_out;
        logic [31:0]        e_out0;
        logic [31:0]        e_out1;
        logic               e_vld;
        logic [SEL_W-1:0]   e_sel;
        logic               e_con;
        logic               e_stk;
        logic [CNT_W-1:0]   e_cnt;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Sources hold the A5A5_0000+i pattern. Source 5 is replaced during
        // the table phase.
        vecs[0]  = '{"cont_first",    1, 0, 0, 32'h00000014, 32'hA5A50002, 32'hA5A50002, 1, 5'd2,  1, 1, 8'd1};
        vecs[1]  = '{"cont_pulse_end",1, 0, 0, 32'h00000020, 32'h12345678, 32'h12345678, 1, 5'd5,  0, 1, 8'd1};
        vecs[2]  = '{"idle",          1, 0, 0, 32'h00000000, 32'h00000000, 32'h12345678, 0, 5'd0,  0, 1, 8'd1};
        vecs[3]  = '{"idle_again",    1, 0, 0, 32'h00000000, 32'h00000000, 32'h12345678, 0, 5'd0,  0, 1, 8'd1};
        vecs[4]  = '{"cont_second",   1, 0, 0, 32'h00000014, 32'hA5A50002, 32'hA5A50002, 1, 5'd2,  1, 1, 8'd2};
        vecs[5]  = '{"stall_hold",    1, 1, 1, 32'h00000080, 32'hA5A50002, 32'hA5A50002, 1, 5'd2,  1, 1, 8'd2};
        vecs[6]  = '{"stall_hold2",   1, 1, 0, 32'h00000000, 32'hA5A50002, 32'hA5A50002, 1, 5'd2,  1, 1, 8'd2};
        vecs[7]  = '{"clr_vs_set",    1, 0, 1, 32'h00000003, 32'hA5A50000, 32'hA5A50000, 1, 5'd0,  1, 1, 8'd1};
        vecs[8]  = '{"err_clr",       1, 0, 1, 32'h00000080, 32'hA5A50007, 32'hA5A50007, 1, 5'd7,  0, 0, 8'd0};
        vecs[9]  = '{"cont_edges",    1, 0, 0, 32'h80000001, 32'hA5A50000, 32'hA5A50000, 1, 5'd0,  1, 1, 8'd1};
        vecs[10] = '{"rst_mid_stall", 0, 1, 1, 32'h00000014, 32'h00000000, 32'h00000000, 0, 5'd0,  0, 0, 8'd0};
        vecs[11] = '{"fresh_idle",    1, 0, 0, 32'h00000000, 32'h00000000, 32'h00000000, 0, 5'd0,  0, 0, 8'd0};
        vecs[12] = '{"src30",         1, 0, 0, 32'h40000000, 32'hA5A5001E, 32'hA5A5001E, 1, 5'd30, 0, 0, 8'd0};

        // Reset behaviour.
        clear    = 1'b0;
        stall    = 1'b0;
        err_clr  = 1'b0;
        src_data = '0;
        src_data[0 +: 32] = 32'hDEADBEEF;
        src_out  = 32'h1;
        step();
        step();
        chk_all("reset", 32'h0, 32'h0, 0, 5'd0, 0, 0, 8'd0);
        clear = 1'b1;
        step();
        chk_all("post_reset", 32'hDEADBEEF, 32'hDEADBEEF, 1, 5'd0, 0, 0, 8'd0);

        // Single-strobe sweep.
        for (int i = 0; i < N_SRC; i++) begin
            src_data[i*DATA_W +: DATA_W] = 32'hA5A50000 + 32'(i);
        end
        for (int i = 0; i < N_SRC; i++) begin
            src_out = N_SRC'(1) << i;
            step();
            chk_all($sformatf("sweep%0d", i), 32'hA5A50000 + 32'(i), 32'hA5A50000 + 32'(i),
                    1, SEL_W'(i), 0, 0, 8'd0);
        end

        // Table: contention, idle modes, stall, err_clr and reset interplay.
        src_data[5*DATA_W +: DATA_W] = 32'h12345678;
        for (int v = 0; v < 13; v++) begin
            clear   = vecs[v].clear;
            stall   = vecs[v].stall;
            err_clr = vecs[v].err_clr;
            src_out = vecs[v].src_out;
            step();
            chk_all(vecs[v].name, vecs[v].e_out0, vecs[v].e_out1, vecs[v].e_vld,
                    vecs[v].e_sel, vecs[v].e_con, vecs[v].e_stk, vecs[v].e_cnt);
        end
        clear   = 1'b1;
        stall   = 1'b0;
        err_clr = 1'b0;

        // Counter saturation. The count starts at 0 here.
        src_out = 32'h00000014;
        for (int n = 0; n < 254; n++) step();
        chk_all("cnt_254", 32'hA5A50002, 32'hA5A50002, 1, 5'd2, 1, 1, 8'd254);
        for (int n = 0; n < 46; n++) step();
        chk_all("cnt_sat", 32'hA5A50002, 32'hA5A50002, 1, 5'd2, 1, 1, 8'd255);
        err_clr = 1'b1;
        src_out = 32'h00000001;
        step();
        chk_all("sat_clear", 32'hA5A50000, 32'hA5A50000, 1, 5'd0, 0, 0, 8'd0);
        err_clr = 1'b0;

`ifdef BUS_MUX_PARITY_EN
        // Parity on words with odd and even numbers of set bits.
        src_data[0 +: 32] = 32'h00000007;
        src_out = 32'h1;
        step();
        chk("parity7_0", 64'(par0), 64'd1);
        chk("parity7_1", 64'(par1), 64'd1);
        src_data[0 +: 32] = 32'h00000003;
        step();
        chk("parity3_0", 64'(par0), 64'd0);
        chk("parity3_1", 64'(par1), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised, registered successor to the datapath bus multiplexer.
- Selects one of N_SRC data sources onto the shared CPU bus using one-hot "Xout" strobes.
- The strobe-to-index encoding happens internally, so no external encoder is needed.
- Adds an output register, a stall/hold control, a no-source mode, and contention detection with a sticky flag and counter.
- Sits between the register file / special registers and the bus; consumed by all bus loads.

Parameters:
- DATA_W, 32, width of each source and of the bus.
- N_SRC, 32, number of sources; legal range 2..64.
- IDLE_HOLD, 0, behaviour when no strobe is active: 0 drives zero, 1 holds the last bus value.
- CNT_W, 8, width of the saturating contention counter.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  synchronous reset, active-low (0 resets on the next clk edge).
- src_data  in  N_SRC*DATA_W  flattened sources; source i occupies bits [i*DATA_W +: DATA_W].
- src_out  in  N_SRC  one-hot source strobes; bit i = source i drives the bus.
- stall  in  1  1 freezes all registered state.
- err_clr  in  1  clears contention_sticky and contention_cnt.
- bus_out  out  DATA_W  registered bus value.
- bus_valid  out  1  registered; 1 = bus_out came from a strobed source.
- bus_sel  out  $clog2(N_SRC)  registered index of the selected source.
- contention  out  1  registered one-cycle pulse: more than one strobe was sampled.
- contention_sticky  out  1  set on any contention, held until err_clr or reset.
- contention_cnt  out  CNT_W  saturating count of contention cycles.

Behaviour:
- Reset: when clear=0 at a clk edge, every output goes to 0, including the held value. Reset takes priority over stall and err_clr.
- Latency: strobes and data sampled at edge k appear on the outputs after edge k; one cycle, fully registered.
- Selection: the lowest-numbered asserted bit of src_out wins (fixed priority).
  - bus_out <= that source's data.
  - bus_sel <= its index.
  - bus_valid <= 1.
- No strobe asserted:
  - bus_valid <= 0 and bus_sel <= 0.
  - IDLE_HOLD=0: bus_out <= 0.
  - IDLE_HOLD=1: bus_out keeps its previous value.
- Contention: popcount(src_out) >= 2 is contention. The priority winner is still driven, and on the same edge:
  - contention <= 1;
  - contention_sticky <= 1;
  - contention_cnt increments, saturating at 2^CNT_W-1 (no wrap).
- No contention: contention <= 0.
- stall=1: all registers (bus_out, bus_valid, bus_sel, contention, sticky, cnt) keep their values. Inputs that cycle are ignored, including contention and err_clr.
- err_clr=1 with stall=0:
  - sticky <= 0 and cnt <= 0.
  - If contention is detected in the same cycle, set wins: sticky <= 1 and cnt <= 1.
  - The contention pulse is unaffected by err_clr.
- Reset asserted mid-stall or mid-contention: the reset values apply on that edge. The first sample after clear returns high is treated as fresh.
- Width rules:
  - bus_sel is zero-extended when N_SRC is not a power of two.
  - src_out bits at or above N_SRC do not exist.
  - No X propagation: unselected sources never reach bus_out.

Optional Feature:
- Macro BUS_MUX_PARITY_EN.
- Defined:
  - Adds output bus_parity (1 bit), the registered even parity (XOR reduction) of the value loaded into bus_out.
  - It follows identical stall, hold and reset rules and resets to 0.
  - In hold mode it keeps the parity of the held value.
- Undefined: the port is absent and there is no parity logic.

Test Plan:
1. Reset: drive clear=0 for 2 cycles with src_out=32'h1 and src_data[R0]=32'hDEADBEEF -> all outputs read 0; after clear=1 and one edge, bus_out=32'hDEADBEEF, bus_valid=1, bus_sel=0.
2. Sweep: strobe each source i=0..31 in turn, with source i data = 32'hA5A50000+i -> one cycle later bus_out=32'hA5A50000+i, bus_sel=i, contention=0, sticky=0.
3. Contention: src_out=32'h00000014 (bits 2 and 4) -> bus_sel=2, bus_out=source 2 data, contention=1 for one cycle, sticky=1, cnt=1; repeat 300 cycles with CNT_W=8 -> cnt=255.
4. Idle modes: strobe source 5 (32'h12345678), then src_out=0 -> with IDLE_HOLD=0, bus_out=0 and bus_valid=0; with IDLE_HOLD=1, bus_out stays 32'h12345678 and bus_valid=0.
5. Stall and clear interaction:
   - stall=1 while changing src_out to source 7 and asserting err_clr -> all outputs unchanged.
   - Then stall=0 with err_clr=1 and src_out=32'h3 -> sticky=1, cnt=1, bus_sel=0.
6. Parity (BUS_MUX_PARITY_EN defined): source data 32'h00000007 -> bus_parity=1; 32'h00000003 -> bus_parity=0, each one cycle after sampling.
